// File: rtl/sd_hex_loader.sv
// sd_hex_loader: finds "MATX_TAG" in SD blocks from START_BLOCK, then parses NUM_BYTES CR/LF-separated ASCII hex pairs.
// Latency: data_valid one cycle after the sd_valid carrying the second hex digit.
// Backpressure: none; the byte rate is set by the sd_card controller through sd_valid.
// Optional macro SD_HEX_LOWERCASE_EN: also accept 'a'-'f' as hex digits.
module sd_hex_loader #(
  parameter logic [31:0] START_BLOCK = 32'h2005,
  parameter int          MAX_BLOCKS  = 16,
  parameter int          NUM_BYTES   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        init_finish,
  input  logic        sd_valid,
  input  logic [7:0]  sd_dout,
  output logic        rd_req,
  output logic [31:0] block_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [7:0]  byte_index
);

  localparam logic [63:0] TAG      = "MATX_TAG";
  localparam logic [8:0]  NB       = 9'(NUM_BYTES);
  localparam logic [31:0] LAST_BLK = 32'(MAX_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_INIT, REQ, RECV} state_t;

  state_t      state;
  logic [9:0]  byte_cnt;   // byte position within the current block
  logic [31:0] blk_cnt;    // blocks searched so far without a tag
  logic [8:0]  out_cnt;    // parsed bytes delivered so far
  logic        found;      // tag seen; later bytes go to the parser
  logic        rejected;   // current block failed the tag compare
  logic        phase;      // 1 = high nibble held, waiting for low digit
  logic [3:0]  hi_nib;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
`ifdef SD_HEX_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
`endif
    return 5'd0;
  endfunction

  logic [4:0] hx;
  logic [7:0] tag_byte;
  logic       is_crlf;
  logic       parse_act;
  logic       p_err;
  logic       p_last;
  logic       all_after;
  logic       blk_end;

  // Classify the incoming byte for the tag matcher and the parser.
  always_comb begin
    hx        = hex_val(sd_dout);
    tag_byte  = TAG[{3'd7 - byte_cnt[2:0], 3'b000} +: 8];
    is_crlf   = (sd_dout == 8'h0D) || (sd_dout == 8'h0A);
    parse_act = found && (out_cnt != NB);
    p_err     = parse_act && (is_crlf ? phase : !hx[4]);
    p_last    = parse_act && !is_crlf && hx[4] && phase && (out_cnt == NB - 9'd1);
    all_after = (out_cnt == NB) || p_last;
    blk_end   = (byte_cnt == 10'd511);
  end

  // Control FSM with registered outputs; rd_req, done and data_valid are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_req     <= 1'b0;
      block_addr <= START_BLOCK;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      byte_index <= 8'd0;
      byte_cnt   <= 10'd0;
      blk_cnt    <= 32'd0;
      out_cnt    <= 9'd0;
      found      <= 1'b0;
      rejected   <= 1'b0;
      phase      <= 1'b0;
      hi_nib     <= 4'd0;
    end else begin
      rd_req     <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err        <= 1'b0;
            busy       <= 1'b1;
            block_addr <= START_BLOCK;
            blk_cnt    <= 32'd0;
            out_cnt    <= 9'd0;
            found      <= 1'b0;
            phase      <= 1'b0;
            state      <= WAIT_INIT;
          end
        end
        WAIT_INIT: begin
          if (init_finish) begin
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          byte_cnt <= 10'd0;
          rejected <= 1'b0;
          state    <= RECV;
        end
        RECV: begin
          if (sd_valid) begin
            byte_cnt <= byte_cnt + 10'd1;
            if (!found) begin
              // Only the first eight bytes of a block can hold the tag.
              if (byte_cnt < 10'd8) begin
                if (sd_dout != tag_byte) rejected <= 1'b1;
                else if (byte_cnt == 10'd7 && !rejected) found <= 1'b1;
              end
            end else if (parse_act) begin
              if (p_err) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else if (!is_crlf) begin
                if (!phase) begin
                  hi_nib <= hx[3:0];
                  phase  <= 1'b1;
                end else begin
                  data_out   <= {hi_nib, hx[3:0]};
                  data_valid <= 1'b1;
                  byte_index <= out_cnt[7:0];
                  out_cnt    <= out_cnt + 9'd1;
                  phase      <= 1'b0;
                end
              end
            end
            // The nibble phase deliberately survives into the next block.
            if (blk_end && !p_err) begin
              if (!found) begin
                if (blk_cnt == LAST_BLK) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end else begin
                  blk_cnt    <= blk_cnt + 32'd1;
                  block_addr <= block_addr + 32'd1;
                  rd_req     <= 1'b1;
                  state      <= REQ;
                end
              end else if (all_after) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                block_addr <= block_addr + 32'd1;
                rd_req     <= 1'b1;
                state      <= REQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_hex_loader.sv
// tb_sd_hex_loader: table-driven scenarios against a behavioural SD card model holding blocks 0x2005..0x2008.
// Each scenario builds a block image, pulses start and checks request/data/done/err summaries.
// Hand-written sequences cover reset values, init wait, mid-block reset and start while busy.
module tb_sd_hex_loader;

  logic        clk = 1'b0;
  logic        reset_n, start, init_finish, sd_valid;
  logic [7:0]  sd_dout;
  logic        rd_req, busy, done, err, data_valid;
  logic [31:0] block_addr;
  logic [7:0]  data_out, byte_index;

  sd_hex_loader #(.START_BLOCK(32'h2005), .MAX_BLOCKS(4), .NUM_BYTES(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .init_finish(init_finish),
    .sd_valid(sd_valid), .sd_dout(sd_dout), .rd_req(rd_req), .block_addr(block_addr),
    .busy(busy), .done(done), .err(err), .data_out(data_out),
    .data_valid(data_valid), .byte_index(byte_index)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] img [4][512];
  logic [7:0] vals [32];
  logic [7:0] vals_xor;

  // Observed activity, cleared before each run.
  int          rd_cnt, dv_cnt, done_cnt, idx_bad;
  logic [31:0] first_addr, last_addr;
  logic [7:0]  first_b, last_b, xr;
  bit          card_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lc);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lc ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  task automatic put_val(input int b, input int pos, input logic [7:0] v, input bit lc);
    img[b][pos]   = hexc(v[7:4], lc);
    img[b][pos+1] = hexc(v[3:0], lc);
    img[b][pos+2] = 8'h0D;
    img[b][pos+3] = 8'h0A;
  endtask

  task automatic put_tag(input int b);
    logic [63:0] t;
    t = "MATX_TAG";
    for (int i = 0; i < 8; i++) img[b][i] = t[8*(7-i) +: 8];
  endtask

  task automatic build(input int scen);
    for (int b = 0; b < 4; b++) for (int i = 0; i < 512; i++) img[b][i] = 8'h00;
    case (scen)
      0: begin put_tag(0); for (int k = 0; k < 32; k++) put_val(0, 8 + 4*k, vals[k], 1'b0); end
      1: begin put_tag(2); for (int k = 0; k < 32; k++) put_val(2, 8 + 4*k, vals[k], 1'b0); end
      3: begin put_tag(0); img[0][8] = "4"; img[0][9] = "G"; end
      4: begin
        put_tag(0);
        for (int i = 8; i < 510; i++) img[0][i] = 8'h0A;
        img[0][510] = 8'h0D; img[0][511] = "7";
        img[1][0] = "E"; img[1][1] = 8'h0D; img[1][2] = 8'h0A;
        for (int k = 1; k < 32; k++) put_val(1, 3 + 4*(k-1), vals[k], 1'b0);
      end
      5: begin
        put_tag(0); put_val(0, 8, vals[0], 1'b1);
        for (int k = 1; k < 32; k++) put_val(0, 8 + 4*k, vals[k], 1'b0);
      end
      6: begin put_tag(0); img[0][8] = "4"; img[0][9] = 8'h0D; end
      7: begin
        for (int b = 0; b < 3; b++) begin
          put_tag(b);
          for (int k = 0; k < 32; k++) put_val(b, 8 + 4*k, vals[k], 1'b0);
        end
        img[0][0] = "X"; img[1][7] = "X";
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] card_byte(input logic [31:0] a, input int i);
    logic [31:0] idx;
    idx = a - 32'h2005;
    if (idx < 32'd4) return img[idx[1:0]][i];
    return 8'h00;
  endfunction

  // SD card model: answers each rd_req with 512 bytes, inserting an idle gap every fifth byte.
  initial begin
    logic [31:0] cur;
    sd_valid = 1'b0;
    sd_dout  = 8'h00;
    forever begin
      if (rd_req && reset_n) begin
        card_busy = 1'b1;
        cur = block_addr;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 512 && reset_n; i++) begin
          sd_valid = 1'b1;
          sd_dout  = card_byte(cur, i);
          @(negedge clk);
          if (i % 5 == 4) begin
            sd_valid = 1'b0;
            @(negedge clk);
          end
        end
        sd_valid  = 1'b0;
        card_busy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rd_req) begin
      rd_cnt++;
      if (rd_cnt == 1) first_addr = block_addr;
      last_addr = block_addr;
    end
    if (data_valid) begin
      if (byte_index != dv_cnt[7:0]) idx_bad++;
      if (dv_cnt == 0) first_b = data_out;
      last_b = data_out;
      xr ^= data_out;
      dv_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_counts();
    rd_cnt = 0; dv_cnt = 0; done_cnt = 0; idx_bad = 0;
    first_addr = 32'd0; last_addr = 32'd0; first_b = 8'd0; last_b = 8'd0; xr = 8'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 6000 && busy; c++) @(negedge clk);
    chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
    for (int c = 0; c < 2000 && card_busy; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rd(input int n);
    for (int c = 0; c < 3000 && rd_cnt < n; c++) @(negedge clk);
    chk("wait_rd_timeout", rd_cnt, n);
  endtask

  typedef struct {
    string       name;
    int          scen;
    int          exp_rd;
    logic [31:0] exp_last_addr;
    int          exp_dv;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    logic [7:0]  exp_xor;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vt [8];

  task automatic run_vec(input vec_t v);
    build(v.scen);
    clear_counts();
    pulse_start();
    wait_idle(v.name);
    chk({v.name, "_rd_cnt"}, rd_cnt, v.exp_rd);
    chk({v.name, "_first_addr"}, first_addr, 32'h2005);
    chk({v.name, "_last_addr"}, last_addr, v.exp_last_addr);
    chk({v.name, "_dv_cnt"}, dv_cnt, v.exp_dv);
    if (v.exp_dv > 0) begin
      chk({v.name, "_first_byte"}, {24'd0, first_b}, {24'd0, v.exp_first});
      chk({v.name, "_last_byte"}, {24'd0, last_b}, {24'd0, v.exp_last});
      chk({v.name, "_xor"}, {24'd0, xr}, {24'd0, v.exp_xor});
      chk({v.name, "_byte_index"}, idx_bad, 0);
    end
    chk({v.name, "_done_cnt"}, done_cnt, v.exp_done);
    chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({v.name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; init_finish = 1'b1;
    clear_counts();
    for (int k = 0; k < 32; k++) vals[k] = 8'(k * 29 + 17);
    vals[0] = 8'h4F; vals[1] = 8'h7E; vals[31] = 8'h54;
    vals_xor = 8'h00;
    for (int k = 0; k < 32; k++) vals_xor ^= vals[k];

    vt[0] = '{"tag_first_blk", 0, 1, 32'h2005, 32, 8'h4F, 8'h54, vals_xor, 1, 1'b0};
    vt[1] = '{"tag_third_blk", 1, 3, 32'h2007, 32, 8'h4F, 8'h54, vals_xor, 1, 1'b0};
    vt[2] = '{"no_tag", 2, 4, 32'h2008, 0, 8'h00, 8'h00, 8'h00, 0, 1'b1};
    vt[3] = '{"bad_digit_G", 3, 1, 32'h2005, 0, 8'h00, 8'h00, 8'h00, 0, 1'b1};
    vt[4] = '{"split_nibble", 4, 2, 32'h2006, 32, 8'h7E, 8'h54, vals_xor ^ 8'h4F ^ 8'h7E, 1, 1'b0};
`ifdef SD_HEX_LOWERCASE_EN
    vt[5] = '{"lowercase", 5, 1, 32'h2005, 32, 8'h4F, 8'h54, vals_xor, 1, 1'b0};
`else
    vt[5] = '{"lowercase", 5, 1, 32'h2005, 0, 8'h00, 8'h00, 8'h00, 0, 1'b1};
`endif
    vt[6] = '{"crlf_odd", 6, 1, 32'h2005, 0, 8'h00, 8'h00, 8'h00, 0, 1'b1};
    vt[7] = '{"partial_tags", 7, 3, 32'h2007, 32, 8'h4F, 8'h54, vals_xor, 1, 1'b0};

    // Reset values while reset_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_block_addr", block_addr, 32'h2005);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_data", {15'd0, data_valid, data_out, byte_index}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) run_vec(vt[v]);

    // Hold init_finish low: no request until the card reports ready.
    build(1);
    clear_counts();
    init_finish = 1'b0;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("init_wait_rd", rd_cnt, 0);
    chk("init_wait_busy", {31'd0, busy}, 32'd1);
    init_finish = 1'b1;
    wait_rd(2);
    chk("mid_addr", block_addr, 32'h2006);

    // Reset in the middle of the second block.
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_block_addr", block_addr, 32'h2005);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("midrst_outs", {29'd0, done, err, data_valid}, 32'd0);
    for (int c = 0; c < 2000 && card_busy; c++) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Fresh load; a start pulse during the second block must be ignored.
    clear_counts();
    pulse_start();
    wait_rd(2);
    repeat (50) @(negedge clk);
    pulse_start();
    wait_idle("restart");
    chk("restart_rd_cnt", rd_cnt, 3);
    chk("restart_first_addr", first_addr, 32'h2005);
    chk("restart_dv_cnt", dv_cnt, 32);
    chk("restart_first_byte", {24'd0, first_b}, 32'h4F);
    chk("restart_done", done_cnt, 1);
    chk("restart_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
